// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine datapath: state encoding,
// load-size codes and the state-to-actuator decode used by the controller.
package wash_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOCK  = 3'd1,
    FILL  = 3'd2,
    WASH  = 3'd3,
    RINSE = 3'd4,
    SPIN  = 3'd5,
    DONE  = 3'd6,
    FAULT = 3'd7
  } state_t;

  localparam logic [1:0] LOAD_S = 2'd0;
  localparam logic [1:0] LOAD_M = 2'd1;
  localparam logic [1:0] LOAD_L = 2'd2;

  typedef struct packed {
    logic doorLock;
    logic fillValve;
    logic motorWash;
    logic motorSpin;
    logic done;
    logic fault;
  } act_t;

  localparam act_t ACT_OFF   = 6'b00_0000;
  localparam act_t ACT_LOCK  = 6'b10_0000;
  localparam act_t ACT_FILL  = 6'b11_0000;
  localparam act_t ACT_WASH  = 6'b10_1000;
  localparam act_t ACT_RINSE = 6'b11_1000;
  localparam act_t ACT_SPIN  = 6'b10_0100;
  localparam act_t ACT_DONE  = 6'b00_0010;
  localparam act_t ACT_FAULT = 6'b00_0001;

  function automatic act_t stateActs(state_t s);
    act_t a;
    case (s)
      LOCK:    a = ACT_LOCK;
      FILL:    a = ACT_FILL;
      WASH:    a = ACT_WASH;
      RINSE:   a = ACT_RINSE;
      SPIN:    a = ACT_SPIN;
      DONE:    a = ACT_DONE;
      FAULT:   a = ACT_FAULT;
      default: a = ACT_OFF;
    endcase
    return a;
  endfunction

  // Code 3 is not a real load size; the timer only has three wash periods.
  function automatic logic [1:0] mapLoad(logic [1:0] sel);
    return (sel == 2'd3) ? LOAD_L : sel;
  endfunction

endpackage

// File: rtl/wash_controller_if.sv
// Bundles the controller's request, timer-flag and actuator signals; the
// slave side is the controller, the master side is whatever drives it.
interface wash_controller_if #(
  parameter int ST_W = 3
);
  logic            start;
  logic            abort;
  logic            door_closed;
  logic [1:0]      load_sel;
  logic            td;
  logic            tf;
  logic            tr;
  logic            ts;
  logic            tw;
  logic [1:0]      load;
  logic            tmr_clr;
  logic            door_lock;
  logic            fill_valve;
  logic            motor_wash;
  logic            motor_spin;
  logic            done;
  logic            fault;
  logic [ST_W-1:0] state;

  modport master (
    output start, abort, door_closed, load_sel, td, tf, tr, ts, tw,
    input  load, tmr_clr, door_lock, fill_valve, motor_wash, motor_spin,
           done, fault, state
  );

  modport slave (
    input  start, abort, door_closed, load_sel, td, tf, tr, ts, tw,
    output load, tmr_clr, door_lock, fill_valve, motor_wash, motor_spin,
           done, fault, state
  );
endinterface

// File: rtl/wash_controller.sv
// Wash program sequencer: walks LOCK..SPIN on the timer's expiry flags,
// repeats RINSE a configurable number of times and traps door-open faults.
module wash_controller
  import wash_pkg::*;
#(
  parameter int RINSES = 2,
  parameter int ST_W   = 3
) (
  input  logic        clk,
  input  logic        reset,
  wash_controller_if.slave bus
);

  localparam logic [1:0] LAST_RINSE = 2'(RINSES - 1);

  state_t     r_state;
  logic [1:0] r_rinseCnt;
  logic [1:0] r_load;
  logic       r_tmrClr;
  act_t       r_act;

  state_t     w_nextState;
  logic       w_reenter;
  logic       w_clrRinse;
  logic       w_incRinse;
  logic       w_latchLoad;
  logic       w_flagOk;
  logic       w_inProgram;

  // A flag seen while tmr_clr is high may be left over from the last phase.
  assign w_flagOk    = !r_tmrClr;
  assign w_inProgram = (r_state >= LOCK) && (r_state <= SPIN);

  always_comb begin
    w_nextState = r_state;
    w_reenter   = 1'b0;
    w_clrRinse  = 1'b0;
    w_incRinse  = 1'b0;
    w_latchLoad = 1'b0;
    if (bus.abort) begin
      w_nextState = IDLE;
      w_clrRinse  = 1'b1;
    end else if (w_inProgram && !bus.door_closed) begin
      w_nextState = FAULT;
    end else begin
      case (r_state)
        IDLE: if (bus.start && bus.door_closed) begin
          w_nextState = LOCK;
          w_latchLoad = 1'b1;
        end
        LOCK:  if (w_flagOk && bus.td) w_nextState = FILL;
        FILL:  if (w_flagOk && bus.tf) w_nextState = WASH;
        WASH:  if (w_flagOk && bus.tw) begin
          w_nextState = RINSE;
          w_clrRinse  = 1'b1;
        end
        RINSE: if (w_flagOk && bus.tr) begin
          if (r_rinseCnt == LAST_RINSE) begin
            w_nextState = SPIN;
          end else begin
            w_incRinse = 1'b1;
            w_reenter  = 1'b1;
          end
        end
        SPIN:  if (w_flagOk && bus.ts) w_nextState = DONE;
        DONE:  if (!bus.start) w_nextState = IDLE;
        FAULT: w_nextState = FAULT;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Actuators are registered from the next state so they stay pure Moore
  // outputs while still changing one cycle after the qualifying input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rinseCnt <= 2'd0;
      r_load     <= LOAD_S;
      r_tmrClr   <= 1'b1;
      r_act      <= ACT_OFF;
    end else begin
      r_state  <= w_nextState;
      r_tmrClr <= (w_nextState != r_state) || w_reenter;
      r_act    <= stateActs(w_nextState);
      if (w_clrRinse) begin
        r_rinseCnt <= 2'd0;
      end else if (w_incRinse) begin
        r_rinseCnt <= r_rinseCnt + 2'd1;
      end
      if (w_latchLoad) begin
        r_load <= mapLoad(bus.load_sel);
      end
    end
  end

  assign bus.load       = r_load;
  assign bus.tmr_clr    = r_tmrClr;
  assign bus.door_lock  = r_act.doorLock;
  assign bus.fill_valve = r_act.fillValve;
  assign bus.motor_wash = r_act.motorWash;
  assign bus.motor_spin = r_act.motorSpin;
  assign bus.done       = r_act.done;
  assign bus.fault      = r_act.fault;
  assign bus.state      = ST_W'(r_state);

endmodule

// File: tb/tb_wash_controller.sv
// Directed scenarios followed by random stimulus, all scored every cycle
// against a program-table model of the wash sequence.
module tb_wash_controller;

  localparam int RINSES = 2;
  localparam int ST_W   = 3;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_TD   = 5'b00001;
  localparam logic [4:0] F_TF   = 5'b00010;
  localparam logic [4:0] F_TW   = 5'b00100;
  localparam logic [4:0] F_TR   = 5'b01000;
  localparam logic [4:0] F_TS   = 5'b10000;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   pulses;

  int         prog[$];
  int         mMode;
  int         mIdx;
  logic       mClr;
  logic [1:0] mLoad;

  wash_controller_if #(.ST_W(ST_W)) bus ();

  wash_controller #(.RINSES(RINSES), .ST_W(ST_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: mode 0 idle, 1 running through prog[mIdx], 2 fault.
  function automatic int mCode();
    if (mMode == 0) return 0;
    if (mMode == 2) return 7;
    return prog[mIdx];
  endfunction

  task automatic modelStep(input logic [4:0] fl);
    int code;
    code = mCode();
    if (!reset) begin
      mMode = 0; mLoad = 2'd0; mClr = 1'b1;
    end else if (bus.abort) begin
      mClr  = (mMode != 0);
      mMode = 0;
    end else if (mMode == 0) begin
      if (bus.start && bus.door_closed) begin
        mMode = 1; mIdx = 0; mClr = 1'b1;
        mLoad = (bus.load_sel == 2'd3) ? 2'd2 : bus.load_sel;
      end else begin
        mClr = 1'b0;
      end
    end else if (mMode == 2) begin
      mClr = 1'b0;
    end else if (code <= 5 && !bus.door_closed) begin
      mMode = 2; mClr = 1'b1;
    end else if (code == 6) begin
      if (!bus.start) begin
        mMode = 0; mClr = 1'b1;
      end else begin
        mClr = 1'b0;
      end
    end else if (!mClr && fl[code-1]) begin
      mIdx++; mClr = 1'b1;
    end else begin
      mClr = 1'b0;
    end
  endtask

  task automatic checkOutput();
    int code;
    logic [5:0] expAct;
    code   = mCode();
    expAct = {(code >= 1 && code <= 5), (code == 2 || code == 4),
              (code == 3 || code == 4), (code == 5), (code == 6), (code == 7)};
    checkValue("state", 32'(bus.state), 32'(code));
    checkValue("load", 32'(bus.load), 32'(mLoad));
    checkValue("tmr_clr", 32'(bus.tmr_clr), 32'(mClr));
    checkValue("actuators", 32'({bus.door_lock, bus.fill_valve, bus.motor_wash,
                                 bus.motor_spin, bus.done, bus.fault}), 32'(expAct));
  endtask

  task automatic applyStimulus(input logic [4:0] fl);
    {bus.ts, bus.tr, bus.tw, bus.tf, bus.td} = fl;
    modelStep(fl);
    @(posedge clk);
    @(negedge clk);
    if (bus.tmr_clr && bus.state != 0) pulses++;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(F_NONE);
  endtask

  task automatic pulseFlag(input logic [4:0] fl);
    idleCycles(2);
    applyStimulus(fl);
  endtask

  task automatic toRinse(input logic [1:0] sel);
    bus.start = 1'b1; bus.door_closed = 1'b1; bus.load_sel = sel;
    applyStimulus(F_NONE);
    pulseFlag(F_TD);
    pulseFlag(F_TF);
    pulseFlag(F_TW);
    idleCycles(2);
  endtask

  initial begin
    prog = {1, 2, 3};
    for (int i = 0; i < RINSES; i++) prog.push_back(4);
    prog.push_back(5);
    prog.push_back(6);
    mMode = 0; mIdx = 0; mClr = 1'b1; mLoad = 2'd0;

    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.door_closed = 1'b1; bus.load_sel = 2'd0;
    {bus.ts, bus.tr, bus.tw, bus.tf, bus.td} = F_NONE;
    @(negedge clk);
    idleCycles(2);
    reset = 1'b1;
    idleCycles(2);

    // Nominal program with medium load.
    pulses = 0;
    bus.start = 1'b1; bus.load_sel = 2'd1;
    applyStimulus(F_NONE);
    pulseFlag(F_TD);
    pulseFlag(F_TF);
    pulseFlag(F_TW);
    pulseFlag(F_TR);
    pulseFlag(F_TR);
    pulseFlag(F_TS);
    idleCycles(2);
    checkValue("nominal_done", 32'(bus.done), 32'd1);
    checkValue("nominal_pulses", 32'(pulses), 32'd7);
    bus.start = 1'b0;
    applyStimulus(F_NONE);
    checkValue("nominal_idle", 32'(bus.state), 32'd0);

    // Load mapping, then door opened during WASH.
    bus.start = 1'b1; bus.load_sel = 2'd3;
    applyStimulus(F_NONE);
    bus.load_sel = 2'd0;
    pulseFlag(F_TD);
    pulseFlag(F_TF);
    idleCycles(2);
    checkValue("load_map", 32'(bus.load), 32'd2);
    bus.door_closed = 1'b0;
    applyStimulus(F_NONE);
    checkValue("door_fault", 32'(bus.state), 32'd7);
    bus.door_closed = 1'b1;
    pulseFlag(F_TW);
    bus.abort = 1'b1;
    applyStimulus(F_NONE);
    bus.abort = 1'b0; bus.start = 1'b0;
    checkValue("fault_abort", 32'(bus.state), 32'd0);
    idleCycles(1);

    // Stale flags held across the FILL->WASH transition.
    bus.start = 1'b1;
    applyStimulus(F_NONE);
    pulseFlag(F_TD);
    idleCycles(2);
    applyStimulus(F_TF | F_TW);
    applyStimulus(F_TF | F_TW);
    idleCycles(2);
    checkValue("stale_hold", 32'(bus.state), 32'd3);
    pulseFlag(F_TW);
    idleCycles(2);

    // Abort colliding with tr in RINSE.
    bus.abort = 1'b1;
    applyStimulus(F_TR);
    bus.abort = 1'b0; bus.start = 1'b0;
    checkValue("abort_rinse", 32'(bus.state), 32'd0);
    idleCycles(1);

    // Door open colliding with ts in SPIN.
    toRinse(2'd2);
    pulseFlag(F_TR);
    pulseFlag(F_TR);
    idleCycles(2);
    bus.door_closed = 1'b0;
    applyStimulus(F_TS);
    checkValue("spin_fault", 32'(bus.state), 32'd7);
    bus.door_closed = 1'b1; bus.abort = 1'b1; bus.start = 1'b0;
    applyStimulus(F_NONE);
    bus.abort = 1'b0;

    // Reset in the middle of RINSE.
    toRinse(2'd1);
    bus.start = 1'b0;
    reset = 1'b0;
    applyStimulus(F_NONE);
    reset = 1'b1;
    checkValue("reset_clr", 32'(bus.tmr_clr), 32'd1);
    checkValue("reset_load", 32'(bus.load), 32'd0);
    idleCycles(2);

    // Random stimulus.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] fl;
      reset           = ($urandom_range(0, 199) != 0);
      bus.abort       = ($urandom_range(0, 49) == 0);
      bus.door_closed = ($urandom_range(0, 39) != 0);
      bus.start       = ($urandom_range(0, 9) != 0);
      bus.load_sel    = 2'($urandom_range(0, 3));
      for (int b = 0; b < 5; b++) fl[b] = ($urandom_range(0, 3) == 0);
      applyStimulus(fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_controller.md
# wash_controller

Sequencing FSM for the washing-machine datapath, directly downstream of the cycle timer. Consumes the timer's one-shot expiry flags (td, tf, tr, ts, tw), drives the timer's load-size select and restart, and produces the actuator enables (door lock, fill valve, wash motor, spin motor). One wash program per start request, with a configurable rinse repeat count, an abort path and a door-open fault path.

## Interface
- `RINSES`, default 2: number of rinse phases per program, legal range 1..3.
- `ST_W`, default 3: width of the state debug output.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-low reset. Sampled on `clk`.
- `start` in 1: level. Requests a program from IDLE. Must drop low before DONE can return to IDLE.
- `abort` in 1: level. Forces return to IDLE from any state.
- `door_closed` in 1: door switch, 1 = closed.
- `load_sel` in 2: requested load size. 0 = small, 1 = medium, 2 = large, 3 = treated as 2.
- `td` in 1: timer door/lock expiry flag.
- `tf` in 1: timer fill expiry flag.
- `tr` in 1: timer rinse expiry flag.
- `ts` in 1: timer spin expiry flag.
- `tw` in 1: timer wash expiry flag; its period depends on `load`.
- `load` out 2: latched load size fed to the timer. Reset 0.
- `tmr_clr` out 1: timer restart pulse. Reset 1.
- `door_lock` out 1: reset 0.
- `fill_valve` out 1: reset 0.
- `motor_wash` out 1: reset 0.
- `motor_spin` out 1: reset 0.
- `done` out 1: reset 0.
- `fault` out 1: reset 0.
- `state` out ST_W: encoded current state, for debug. Reset IDLE (0).

## Operation
- States and their encoding: IDLE=0, LOCK=1, FILL=2, WASH=3, RINSE=4, SPIN=5, DONE=6, FAULT=7.
- **IDLE**: all actuators off.
  - `start & door_closed` moves to LOCK.
  - On that transition, `load_sel` is latched into `load`, with 3 mapped to 2.
- **LOCK**: `door_lock`=1. `td` moves to FILL.
- **FILL**: `door_lock`, `fill_valve`=1. `tf` moves to WASH.
- **WASH**: `door_lock`, `motor_wash`=1. `tw` moves to RINSE.
- **RINSE**: `door_lock`, `fill_valve`, `motor_wash`=1.
  - On `tr`: if `rinse_cnt`==RINSES-1, move to SPIN.
  - Otherwise increment `rinse_cnt` and re-enter RINSE; re-entry counts as a transition and issues `tmr_clr`.
  - `rinse_cnt` is 2 bits and is cleared when RINSE is first entered from WASH.
- **SPIN**: `door_lock`, `motor_spin`=1. `ts` moves to DONE.
- **DONE**: `done`=1, `door_lock`=0. `!start` moves to IDLE.
- **FAULT**:
  - Entered from LOCK..SPIN whenever `door_closed`=0.
  - All actuators off, `fault`=1.
  - Sticky; leaves only via `abort` (to IDLE) or reset.
- Priority, highest first: reset > abort > door-open fault > timer flag > hold.
- `abort` in IDLE is a no-op. `abort` clears `rinse_cnt` but leaves `load` unchanged.
- `load` holds its value through the program. It is updated only on the IDLE→LOCK transition.

## Timing
- Moore machine. All outputs are registered and are functions of the state register.
- Actuator outputs change in the cycle after the qualifying input is sampled (1-cycle latency).
- `tmr_clr` rules:
  - Registered, high for exactly one cycle, namely the first cycle of every newly entered state, including RINSE re-entry and IDLE entry.
  - Also high in the first cycle after reset release.
- Timer flags are ignored in any cycle where `tmr_clr`=1, so a stale expiry from the previous phase cannot skip a phase.
- Flags not belonging to the current state are ignored. Example: `ts` in WASH does nothing.
- Simultaneous events:
  - `abort` and a flag in the same cycle: abort wins.
  - Door open and a flag in the same cycle: FAULT wins.
- Reset mid-program: the next cycle is IDLE with all actuators off, and `load`=0, `rinse_cnt`=0.

## Structure
- Shared package `wash_pkg` holds:
  - the state enum and its encoding;
  - load-size constants LOAD_S/M/L = 0/1/2;
  - the state-to-actuator decode constants.
  The timer and the top level use the same package.
- No sub-module is needed: one state register, one 2-bit rinse counter and one load register, in a single module.

## Test plan
- **Nominal program**: reset, then `start`=1, `door_closed`=1, `load_sel`=1. Pulse `td`, `tf`, `tw`, `tr`, `tr`, `ts` one at a time, at least 2 cycles apart.
  - State sequence must be 1,2,3,4,4,5,6.
  - `load`=1 throughout.
  - `tmr_clr` must pulse once per entry, 7 pulses in total.
  - `done`=1 until `start`=0, then IDLE.
- **Load mapping**: `load_sel`=3 at start → `load`=2. A change of `load_sel` mid-program leaves `load` unchanged.
- **Door open**: in WASH, drop `door_closed` → next cycle `state`=7, `fault`=1, all actuators 0. Pulsing `tw` afterwards has no effect. Asserting `abort` → IDLE.
- **Stale flag**: hold `tf` high across the FILL→WASH transition. WASH must not advance on the `tmr_clr` cycle; a fresh `tw` is required.
- **Collisions**:
  - `abort` with `tr` in RINSE → IDLE.
  - Door open with `ts` in SPIN → FAULT, not DONE.
- **Reset mid-RINSE**: drive `reset`=0 for one cycle → `state`=0, all outputs at reset values, `tmr_clr`=1 in the first cycle after release.
